// File: rtl/parking_slot_allocator.sv
// Entry-gate slot allocator: grants the lowest free parking space, holds it reserved until the
// car is seen parked or the reservation times out, and publishes free-space count / lot-full.
module parking_slot_allocator #(
  parameter int unsigned NUM_SPACES   = 8,
  parameter int unsigned ID_W         = 3,
  parameter int unsigned RESV_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SPACES-1:0] parking_spaces,
  input  logic                  entry_req,
  output logic                  entry_ack,
  output logic [ID_W-1:0]       slot_id,
  output logic [NUM_SPACES-1:0] reserved,
  output logic [ID_W:0]         free_count,
  output logic                  full,
  output logic                  timeout_evt,
  output logic [ID_W-1:0]       timeout_slot
);

  localparam int unsigned FcW = ID_W + 1;

  typedef enum logic [1:0] {StIdle, StGrant, StWaitDrop} state_e;

  state_e                state_q;
  logic                  entry_ack_q;
  logic [ID_W-1:0]       slot_id_q;
  logic                  timeout_evt_q;
  logic [ID_W-1:0]       timeout_slot_q;
  logic [NUM_SPACES-1:0] reserved_q, reserved_d;
  logic [CNT_W-1:0]      timer_q [NUM_SPACES];
  logic [CNT_W-1:0]      timer_d [NUM_SPACES];

  logic [NUM_SPACES-1:0] avail;
  logic [NUM_SPACES-1:0] expire;
  logic                  pick_vld;
  logic [ID_W-1:0]       pick;
  logic                  exp_any;
  logic [ID_W-1:0]       exp_idx;
  logic                  grant;

  assign avail = ~parking_spaces & ~reserved_q;
  assign grant = (state_q == StIdle) && entry_req && pick_vld;

  // Lowest-index free space (scan high to low so the lowest wins).
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = NUM_SPACES - 1; i >= 0; i--) begin
      if (avail[i]) begin
        pick_vld = 1'b1;
        pick     = ID_W'(i);
      end
    end
  end

  // Free-space popcount and lot-full flag for the gate display.
  always_comb begin
    free_count = '0;
    for (int i = 0; i < NUM_SPACES; i++) begin
      free_count = free_count + FcW'(avail[i]);
    end
    full = (free_count == '0);
  end

  // Per-slot reservation ageing; parking wins over expiry, a new grant loads a fresh timer.
  always_comb begin
    reserved_d = reserved_q;
    expire     = '0;
    for (int i = 0; i < NUM_SPACES; i++) begin
      timer_d[i] = timer_q[i];
      if (reserved_q[i]) begin
        if (parking_spaces[i]) begin
          reserved_d[i] = 1'b0;
          timer_d[i]    = '0;
        end else if (timer_q[i] == CNT_W'(1)) begin
          reserved_d[i] = 1'b0;
          timer_d[i]    = '0;
          expire[i]     = 1'b1;
        end else begin
          timer_d[i] = timer_q[i] - CNT_W'(1);
        end
      end
    end
    // A granted slot is never currently reserved, so this cannot clash with the ageing above.
    if (grant) begin
      reserved_d[pick] = 1'b1;
      timer_d[pick]    = CNT_W'(RESV_TIMEOUT);
    end
  end

  // Lowest expiring index; only that one is reported when several expire together.
  always_comb begin
    exp_any = 1'b0;
    exp_idx = '0;
    for (int i = NUM_SPACES - 1; i >= 0; i--) begin
      if (expire[i]) begin
        exp_any = 1'b1;
        exp_idx = ID_W'(i);
      end
    end
  end

  // Request FSM with registered grant/timeout outputs and reservation state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      entry_ack_q    <= 1'b0;
      slot_id_q      <= '0;
      timeout_evt_q  <= 1'b0;
      timeout_slot_q <= '0;
      reserved_q     <= '0;
      for (int i = 0; i < NUM_SPACES; i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      reserved_q    <= reserved_d;
      timeout_evt_q <= exp_any;
      if (exp_any) begin
        timeout_slot_q <= exp_idx;
      end
      for (int i = 0; i < NUM_SPACES; i++) begin
        timer_q[i] <= timer_d[i];
      end
      case (state_q)
        StIdle: begin
          if (grant) begin
            entry_ack_q <= 1'b1;
            slot_id_q   <= pick;
            state_q     <= StGrant;
          end
        end
        StGrant: begin
          entry_ack_q <= 1'b0;
          state_q     <= StWaitDrop;
        end
        StWaitDrop: begin
          // A request still held from the last grant must drop before another is served.
          if (!entry_req) begin
            state_q <= StIdle;
          end
        end
        default: begin
          entry_ack_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign entry_ack    = entry_ack_q;
  assign slot_id      = slot_id_q;
  assign reserved     = reserved_q;
  assign timeout_evt  = timeout_evt_q;
  assign timeout_slot = timeout_slot_q;

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Directed bench for parking_slot_allocator: a cycle table plus hand sequences for the
// held-request, timeout, park-at-expiry and mid-reservation reset cases.
module tb_parking_slot_allocator;

  logic       clk;
  logic       rst_n;
  logic [7:0] parking_spaces;
  logic       entry_req;
  logic       entry_ack;
  logic [2:0] slot_id;
  logic [7:0] reserved;
  logic [3:0] free_count;
  logic       full;
  logic       timeout_evt;
  logic [2:0] timeout_slot;

  int n_tests = 0;
  int n_fail  = 0;

  parking_slot_allocator #(
    .NUM_SPACES  (8),
    .ID_W        (3),
    .RESV_TIMEOUT(16),
    .CNT_W       (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .parking_spaces(parking_spaces),
    .entry_req     (entry_req),
    .entry_ack     (entry_ack),
    .slot_id       (slot_id),
    .reserved      (reserved),
    .free_count    (free_count),
    .full          (full),
    .timeout_evt   (timeout_evt),
    .timeout_slot  (timeout_slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [7:0] occ;
    logic       req;
    logic       ack;
    logic [2:0] sid;
    logic [7:0] res;
    logic [3:0] fc;
    logic       full;
    logic       tevt;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Active edge, then settle 1 time unit before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    entry_req      = 1'b0;
    parking_spaces = 8'h00;
    tick();
    rst_n = 1'b1;
  endtask

  int n_ack;
  int first_evt;
  int n_evt;
  logic [2:0] ack_sid;
  logic [2:0] evt_slot;

  initial begin
    rst_n          = 1'b0;
    entry_req      = 1'b0;
    parking_spaces = 8'h00;

    // Inputs applied before an edge; expected outputs sampled just after it.
    //            rst   occ    req   ack   sid   res    fc     full  tevt
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 4'd8, 1'b0, 1'b0}; // reset
    vecs[1]  = '{1'b1, 8'h00, 1'b1, 1'b1, 3'd0, 8'h01, 4'd7, 1'b0, 1'b0}; // grant slot 0
    vecs[2]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h01, 4'd7, 1'b0, 1'b0}; // one-cycle ack
    vecs[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h01, 4'd7, 1'b0, 1'b0}; // drop -> idle
    vecs[4]  = '{1'b1, 8'h01, 1'b0, 1'b0, 3'd0, 8'h00, 4'd7, 1'b0, 1'b0}; // car parks slot 0
    vecs[5]  = '{1'b1, 8'h07, 1'b1, 1'b1, 3'd3, 8'h08, 4'd4, 1'b0, 1'b0}; // grant slot 3
    vecs[6]  = '{1'b1, 8'h07, 1'b0, 1'b0, 3'd3, 8'h08, 4'd4, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h0F, 1'b0, 1'b0, 3'd3, 8'h00, 4'd4, 1'b0, 1'b0}; // parks slot 3
    vecs[8]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00, 4'd0, 1'b1, 1'b0}; // lot full, no ack
    vecs[9]  = '{1'b1, 8'hBF, 1'b1, 1'b1, 3'd6, 8'h40, 4'd0, 1'b1, 1'b0}; // slot 6 frees
    vecs[10] = '{1'b1, 8'hBF, 1'b0, 1'b0, 3'd6, 8'h40, 4'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'hBF, 1'b0, 1'b0, 3'd0, 8'h00, 4'd1, 1'b0, 1'b0}; // reset drops resv
    vecs[12] = '{1'b1, 8'hBD, 1'b0, 1'b0, 3'd0, 8'h00, 4'd2, 1'b0, 1'b0}; // car leaves slot 1
    vecs[13] = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 4'd8, 1'b0, 1'b0};

    #2;
    for (int i = 0; i < 14; i++) begin
      rst_n          = vecs[i].rst_n;
      parking_spaces = vecs[i].occ;
      entry_req      = vecs[i].req;
      tick();
      check($sformatf("v%0d ack", i), 32'(entry_ack), 32'(vecs[i].ack));
      check($sformatf("v%0d slot_id", i), 32'(slot_id), 32'(vecs[i].sid));
      check($sformatf("v%0d reserved", i), 32'(reserved), 32'(vecs[i].res));
      check($sformatf("v%0d free_count", i), 32'(free_count), 32'(vecs[i].fc));
      check($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].full));
      check($sformatf("v%0d timeout_evt", i), 32'(timeout_evt), 32'(vecs[i].tevt));
    end

    // Held request for 10 cycles yields exactly one ack, for slot 3.
    do_reset();
    parking_spaces = 8'h07;
    entry_req      = 1'b1;
    n_ack          = 0;
    ack_sid        = 3'd0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (entry_ack) begin
        n_ack++;
        ack_sid = slot_id;
      end
    end
    check("held_req ack count", 32'(n_ack), 32'd1);
    check("held_req slot", 32'(ack_sid), 32'd3);
    check("held_req reserved", 32'(reserved), 32'h08);
    entry_req = 1'b0;
    tick();

    // Unused reservation of slot 0 expires exactly 16 edges after the grant edge.
    do_reset();
    entry_req = 1'b1;
    tick();
    check("tmo grant ack", 32'(entry_ack), 32'd1);
    entry_req = 1'b0;
    first_evt = 0;
    n_evt     = 0;
    evt_slot  = 3'd7;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 15) check("tmo resv before expiry", 32'(reserved), 32'h01);
      if (k == 16) check("tmo resv at expiry", 32'(reserved), 32'h00);
      if (timeout_evt) begin
        n_evt++;
        if (first_evt == 0) begin
          first_evt = k;
          evt_slot  = timeout_slot;
        end
      end
    end
    check("tmo evt cycle", 32'(first_evt), 32'd16);
    check("tmo evt pulses", 32'(n_evt), 32'd1);
    check("tmo evt slot", 32'(evt_slot), 32'd0);
    check("tmo free_count", 32'(free_count), 32'd8);

    // Occupancy arriving on the expiry edge counts as parked: no timeout event.
    do_reset();
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    for (int k = 1; k <= 15; k++) tick();
    check("park@exp resv held", 32'(reserved), 32'h01);
    parking_spaces = 8'h01;
    tick();
    check("park@exp evt", 32'(timeout_evt), 32'd0);
    check("park@exp resv", 32'(reserved), 32'h00);
    tick();
    check("park@exp evt later", 32'(timeout_evt), 32'd0);

    // Two reservations outstanding, then a one-cycle reset clears everything.
    do_reset();
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    tick();
    tick();
    entry_req = 1'b1;
    tick();
    check("rst2 second grant slot", 32'(slot_id), 32'd1);
    check("rst2 two reserved", 32'(reserved), 32'h03);
    rst_n = 1'b0;
    tick();
    check("rst2 reserved", 32'(reserved), 32'h00);
    check("rst2 free_count", 32'(free_count), 32'd8);
    check("rst2 ack", 32'(entry_ack), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst2 idle regrant ack", 32'(entry_ack), 32'd1);
    check("rst2 idle regrant slot", 32'(slot_id), 32'd0);
    entry_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
